// File: rtl/trigger_matcher.sv
// trigger_matcher
//
// Compares each valid 64-channel logic sample against five trigger masks and
// reports when the capture trigger condition is met. Arm starts a sequence:
// an optional holdoff of ignored samples, then a search for a run of
// consecutive matching samples. Abort returns to idle at any time.
//
// Ports:
//   in_clk, in_rst_n        clock, asynchronous active-low reset
//   in_sample_valid         qualifies in_sample for one cycle
//   in_sample               sampled channel levels
//   in_mask_0..in_mask_4    care / level-high / level-low / rising / falling
//   in_arm, in_abort        single-cycle control requests (abort wins)
//   in_holdoff              valid samples ignored after arm
//   in_match_len            consecutive matches required (0 acts as 1)
//   out_state               0 IDLE, 1 HOLDOFF, 2 SEARCH, 3 DONE
//   out_armed               high in HOLDOFF or SEARCH
//   out_triggered           high in DONE
//   out_trig_pulse          one-cycle pulse when the trigger fires
//   out_trig_index          index of the completing sample (0 = first after arm)
module trigger_matcher #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_sample_valid,
    input  logic [WIDTH-1:0] in_sample,
    input  logic [WIDTH-1:0] in_mask_0,
    input  logic [WIDTH-1:0] in_mask_1,
    input  logic [WIDTH-1:0] in_mask_2,
    input  logic [WIDTH-1:0] in_mask_3,
    input  logic [WIDTH-1:0] in_mask_4,
    input  logic             in_arm,
    input  logic             in_abort,
    input  logic [CNT_W-1:0] in_holdoff,
    input  logic [CNT_W-1:0] in_match_len,
    output logic [1:0]       out_state,
    output logic             out_armed,
    output logic             out_triggered,
    output logic             out_trig_pulse,
    output logic [31:0]      out_trig_index
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_SEARCH  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Sample index saturates instead of wrapping.
    function automatic logic [31:0] idx_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A zero match length is treated as a single-sample match.
    function automatic logic [CNT_W-1:0] len_clamp(input logic [CNT_W-1:0] l);
        return (l == '0) ? CNT_W'(1) : l;
    endfunction

    state_t           state, state_nx;
    logic [WIDTH-1:0] prev;
    logic             prev_ok;
    logic [CNT_W-1:0] hold_r, len_r;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic [CNT_W-1:0] run_cnt, run_cnt_nx;
    logic [31:0]      idx, idx_nx;
    logic [CNT_W:0]   hold_inc, run_inc;
    logic             fire, restart;

    logic [WIDTH-1:0] rise, fall, bit_ok;
    logic             sample_match;

    // Edge conditions need a real previous sample; before the first valid
    // sample after reset they can never be satisfied.
    assign rise   = {WIDTH{prev_ok}} & ~prev & in_sample;
    assign fall   = {WIDTH{prev_ok}} & prev & ~in_sample;
    assign bit_ok = ~in_mask_0 | ((~in_mask_1 | in_sample) &
                                  (~in_mask_2 | ~in_sample) &
                                  (~in_mask_3 | rise) &
                                  (~in_mask_4 | fall));
    assign sample_match = &bit_ok;

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        run_cnt_nx  = run_cnt;
        idx_nx      = idx;
        fire        = 1'b0;
        restart     = 1'b0;
        hold_inc    = {1'b0, hold_cnt} + 1'b1;
        run_inc     = {1'b0, run_cnt} + 1'b1;

        if (in_abort) begin
            state_nx = ST_IDLE;
        end else if (in_arm) begin
            // Any arm, from any state, restarts the whole sequence.
            restart     = 1'b1;
            hold_cnt_nx = '0;
            run_cnt_nx  = '0;
            idx_nx      = '0;
            state_nx    = (in_holdoff != '0) ? ST_HOLDOFF : ST_SEARCH;
        end else if (in_sample_valid) begin
            case (state)
                ST_HOLDOFF: begin
                    hold_cnt_nx = hold_inc[CNT_W-1:0];
                    idx_nx      = idx_inc(idx);
                    if (hold_inc == {1'b0, hold_r})
                        state_nx = ST_SEARCH;
                end
                ST_SEARCH: begin
                    idx_nx = idx_inc(idx);
                    if (sample_match) begin
                        if (run_inc >= {1'b0, len_r}) begin
                            run_cnt_nx = len_r;
                            fire       = 1'b1;
                            state_nx   = ST_DONE;
                        end else begin
                            run_cnt_nx = run_inc[CNT_W-1:0];
                        end
                    end else begin
                        run_cnt_nx = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state          <= ST_IDLE;
            prev           <= '0;
            prev_ok        <= 1'b0;
            hold_r         <= '0;
            len_r          <= '0;
            hold_cnt       <= '0;
            run_cnt        <= '0;
            idx            <= '0;
            out_armed      <= 1'b0;
            out_triggered  <= 1'b0;
            out_trig_pulse <= 1'b0;
            out_trig_index <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            run_cnt  <= run_cnt_nx;
            idx      <= idx_nx;
            // The previous-sample history tracks every valid sample,
            // including one presented alongside arm.
            if (in_sample_valid) begin
                prev    <= in_sample;
                prev_ok <= 1'b1;
            end
            if (restart) begin
                hold_r <= in_holdoff;
                len_r  <= len_clamp(in_match_len);
            end
            out_trig_pulse <= fire;
            if (restart)
                out_trig_index <= '0;
            else if (fire)
                out_trig_index <= idx;
            out_armed     <= (state_nx == ST_HOLDOFF) || (state_nx == ST_SEARCH);
            out_triggered <= (state_nx == ST_DONE);
        end
    end

    assign out_state = state;

endmodule

// File: tb/tb_trigger_matcher.sv
module tb_trigger_matcher;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        valid, arm, abort;
    logic [63:0] sample, m0, m1, m2, m3, m4;
    logic [15:0] hold, len;
    logic [1:0]  out_state;
    logic        out_armed, out_triggered, out_trig_pulse;
    logic [31:0] out_trig_index;

    always #5 in_clk = ~in_clk;

    trigger_matcher #(.WIDTH(64), .CNT_W(16)) dut (
        .in_clk          (in_clk),
        .in_rst_n        (in_rst_n),
        .in_sample_valid (valid),
        .in_sample       (sample),
        .in_mask_0       (m0),
        .in_mask_1       (m1),
        .in_mask_2       (m2),
        .in_mask_3       (m3),
        .in_mask_4       (m4),
        .in_arm          (arm),
        .in_abort        (abort),
        .in_holdoff      (hold),
        .in_match_len    (len),
        .out_state       (out_state),
        .out_armed       (out_armed),
        .out_triggered   (out_triggered),
        .out_trig_pulse  (out_trig_pulse),
        .out_trig_index  (out_trig_index)
    );

    typedef struct {
        logic        arm;
        logic        abort;
        logic        valid;
        logic [63:0] s;
        logic [63:0] m0, m1, m2, m3, m4;
        logic [15:0] hold, len;
        logic [1:0]  st;
        logic        pulse;
        logic [31:0] idx;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] c_m0, c_m1, c_m2, c_m3, c_m4;
    logic [15:0] c_hold, c_len;
    int          ntests = 0;
    int          nfail  = 0;

    task automatic add(input logic a, input logic ab, input logic v, input logic [63:0] s,
                       input logic [1:0] st, input logic p, input logic [31:0] idx);
        vec_t r;
        r.arm = a; r.abort = ab; r.valid = v; r.s = s;
        r.m0 = c_m0; r.m1 = c_m1; r.m2 = c_m2; r.m3 = c_m3; r.m4 = c_m4;
        r.hold = c_hold; r.len = c_len;
        r.st = st; r.pulse = p; r.idx = idx;
        vecs.push_back(r);
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic a, input logic ab, input logic v, input logic [63:0] s);
        arm = a; abort = ab; valid = v; sample = s;
        @(posedge in_clk);
        #1;
        arm = 1'b0; abort = 1'b0; valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [1:0] st, input logic p, input logic [31:0] idx);
        logic ok;
        ntests++;
        ok = (out_state === st) && (out_trig_pulse === p) &&
             (out_triggered === (st == 2'd3)) &&
             (out_armed === ((st == 2'd1) || (st == 2'd2))) &&
             (out_trig_index === idx);
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got state=%0d pulse=%b trig=%b armed=%b idx=%0d, required state=%0d pulse=%b idx=%0d",
                     name, out_state, out_trig_pulse, out_triggered, out_armed, out_trig_index, st, p, idx);
        end
    endtask

    initial begin
        in_rst_n = 1'b0;
        valid = 1'b0; arm = 1'b0; abort = 1'b0; sample = '0;
        m0 = '0; m1 = '0; m2 = '0; m3 = '0; m4 = '0;
        hold = '0; len = 16'd1;

        repeat (2) @(posedge in_clk);
        #1;
        chk("reset", 2'd0, 1'b0, 32'd0);
        in_rst_n = 1'b1;

        // Level trigger on bit 0.
        c_m0 = '1; c_m1 = 64'h1; c_m2 = '0; c_m3 = '0; c_m4 = '0; c_hold = 16'd0; c_len = 16'd1;
        add(1, 0, 0, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd3, 1, 32'd2);
        add(0, 0, 0, 64'h0, 2'd3, 0, 32'd2);

        // Rising edge on bit 5; sample before arm primes prev, re-arm from DONE.
        c_m0 = 64'h20; c_m1 = '0; c_m3 = 64'h20;
        add(0, 0, 1, 64'h20, 2'd3, 0, 32'd2);
        add(1, 0, 0, 64'h0,  2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h20, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h00, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h20, 2'd3, 1, 32'd2);

        // Holdoff of 3 with an always-true condition; sample with arm is not counted.
        c_m0 = '0; c_m3 = '0; c_hold = 16'd3;
        add(1, 0, 1, 64'h1, 2'd1, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd1, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd1, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd3, 1, 32'd3);

        // Run length 3, pattern M,M,N,M,M,M.
        c_m0 = 64'h1; c_m1 = 64'h1; c_hold = 16'd0; c_len = 16'd3;
        add(1, 0, 0, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd3, 1, 32'd5);

        // Length 0 acts as 1; re-arm directly after the pulse cycle.
        c_len = 16'd0;
        add(1, 0, 0, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h1, 2'd3, 1, 32'd1);

        // Contradictory level-high and level-low on a cared bit never matches.
        c_m0 = 64'h1; c_m1 = 64'h1; c_m2 = 64'h1; c_len = 16'd1;
        add(1, 0, 0, 64'h0, 2'd2, 0, 32'd0);
        for (int i = 0; i < 100; i++)
            add(0, 0, 1, 64'(i % 2), 2'd2, 0, 32'd0);
        // Same conditions with the care bit cleared match at once.
        c_m0 = '0;
        add(1, 0, 0, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h0, 2'd3, 1, 32'd0);

        // Falling edge on bit 1.
        c_m0 = 64'h2; c_m1 = '0; c_m2 = '0; c_m4 = 64'h2;
        add(1, 0, 0, 64'h0, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h2, 2'd2, 0, 32'd0);
        add(0, 0, 1, 64'h0, 2'd3, 1, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            m0 = vecs[i].m0; m1 = vecs[i].m1; m2 = vecs[i].m2;
            m3 = vecs[i].m3; m4 = vecs[i].m4;
            hold = vecs[i].hold; len = vecs[i].len;
            step(vecs[i].arm, vecs[i].abort, vecs[i].valid, vecs[i].s);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].pulse, vecs[i].idx);
        end

        // Abort from DONE keeps the index.
        step(0, 1, 0, 64'h0);
        chk("abort_done", 2'd0, 1'b0, 32'd1);

        m0 = 64'h1; m1 = 64'h1; m2 = '0; m3 = '0; m4 = '0; hold = '0; len = 16'd1;
        step(1, 1, 0, 64'h0);
        chk("arm_abort_idle", 2'd0, 1'b0, 32'd1);
        step(1, 0, 0, 64'h0);
        chk("arm", 2'd2, 1'b0, 32'd0);
        step(0, 0, 1, 64'h0);
        chk("search_nomatch", 2'd2, 1'b0, 32'd0);
        step(0, 1, 0, 64'h0);
        chk("abort_search", 2'd0, 1'b0, 32'd0);
        step(1, 0, 0, 64'h0);
        chk("rearm", 2'd2, 1'b0, 32'd0);
        step(1, 1, 1, 64'h1);
        chk("arm_abort_search", 2'd0, 1'b0, 32'd0);

        // Asynchronous reset mid-SEARCH, away from any clock edge.
        step(1, 0, 0, 64'h0);
        step(0, 0, 1, 64'h0);
        chk("pre_reset", 2'd2, 1'b0, 32'd0);
        #2 in_rst_n = 1'b0;
        #1 chk("async_reset_search", 2'd0, 1'b0, 32'd0);
        #2 in_rst_n = 1'b1;

        // After reset there is no previous sample, so the first sample is no edge.
        m0 = 64'h20; m1 = '0; m3 = 64'h20;
        step(1, 0, 0, 64'h0);
        chk("arm_after_reset", 2'd2, 1'b0, 32'd0);
        step(0, 0, 1, 64'h20);
        chk("no_edge_after_reset", 2'd2, 1'b0, 32'd0);
        step(0, 0, 1, 64'h0);
        chk("fall_not_rise", 2'd2, 1'b0, 32'd0);
        step(0, 0, 1, 64'h20);
        chk("rise_after_reset", 2'd3, 1'b1, 32'd2);
        step(0, 0, 0, 64'h0);
        chk("pulse_one_cycle", 2'd3, 1'b0, 32'd2);

        // Asynchronous reset in DONE clears the index too.
        #2 in_rst_n = 1'b0;
        #1 chk("async_reset_done", 2'd0, 1'b0, 32'd0);
        #2 in_rst_n = 1'b1;
        step(0, 0, 0, 64'h0);
        chk("idle_after_reset", 2'd0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/trigger_matcher.md
# trigger_matcher

Downstream consumer of the five 64-bit trigger masks produced by the mask register block. Each valid 64-channel logic sample is compared against those masks to detect the capture trigger, with arm/abort control, a post-arm holdoff and a required run of consecutive matches. The block reports trigger status and the trigger sample index to the capture controller.

## Interface
Parameters:
- WIDTH, 64, channel count; equals mask width.
- CNT_W, 16, width of the holdoff and match-length operands.

Ports:
- in_clk  in  1  sole clock; all state changes on its rising edge.
- in_rst_n  in  1  asynchronous, active-low reset.
- in_sample_valid  in  1  qualifies in_sample for one cycle.
- in_sample  in  WIDTH  sampled channel levels.
- in_mask_0  in  WIDTH  care mask; 1 = channel participates.
- in_mask_1  in  WIDTH  level-high condition.
- in_mask_2  in  WIDTH  level-low condition.
- in_mask_3  in  WIDTH  rising-edge condition.
- in_mask_4  in  WIDTH  falling-edge condition.
- in_arm  in  1  single-cycle arm/re-arm request.
- in_abort  in  1  single-cycle abort request.
- in_holdoff  in  CNT_W  count of valid samples ignored after arm.
- in_match_len  in  CNT_W  required consecutive matching samples; 0 is treated as 1.
- out_state  out  2  0 IDLE, 1 HOLDOFF, 2 SEARCH, 3 DONE.
- out_armed  out  1  high in HOLDOFF or SEARCH.
- out_triggered  out  1  high in DONE.
- out_trig_pulse  out  1  one-cycle pulse on trigger.
- out_trig_index  out  32  index of the completing sample; the first valid sample after arm is index 0.

## Operation
- Previous-sample register: prev and prev_ok are updated on every valid sample, in every state.
- Bit match rule, for bit i:
  - If mask_0[i]=0, the bit always matches.
  - Otherwise all set conditions must hold: mask_1 needs s=1; mask_2 needs s=0; mask_3 needs prev=0 and s=1; mask_4 needs prev=1 and s=0.
  - Edge conditions are false while prev_ok=0.
- Sample match = AND of all bit matches, evaluated combinationally against the live mask inputs.
- Arm latches in_holdoff to hold_r and max(in_match_len,1) to len_r. It also clears the sample index, the holdoff counter and the run counter, and clears out_trig_index.
- State transitions:
  - IDLE: arm → HOLDOFF if in_holdoff≠0, else SEARCH.
  - HOLDOFF: each valid sample increments hold_cnt and the sample index; when hold_cnt+1 = hold_r → SEARCH. No matching is done in this state.
  - SEARCH, valid sample that matches: run_cnt+1. If run_cnt+1 ≥ len_r → DONE, set out_trig_pulse, and load out_trig_index with the current index.
  - SEARCH, valid sample that does not match: run_cnt ← 0.
  - SEARCH: the index increments on every valid sample.
  - DONE: holds out_triggered and out_trig_index until arm or abort.
  - Arm in HOLDOFF, SEARCH or DONE restarts the sequence exactly as an arm from IDLE.
- Abort from any state → IDLE and clears out_triggered. out_trig_index is retained.
- Arm and abort in the same cycle: abort wins.
- The sample index saturates at 32'hFFFF_FFFF; it does not wrap.
- run_cnt saturates at len_r.
- in_sample_valid low: no counter or state advance, except that arm and abort still act.

## Timing
- Reset, asynchronous and immediate:
  - out_state=0, out_armed=0, out_triggered=0, out_trig_pulse=0, out_trig_index=0.
  - prev=0, prev_ok=0, and all counters 0.
- All outputs are registered.
- Trigger latency: out_trig_pulse, out_triggered and out_trig_index update one edge after the edge that samples the completing valid sample.
- Arm latency: out_armed is high the cycle after in_arm. A valid sample presented in the same cycle as arm is not counted; it updates prev only.
- Mask changes take effect on the next evaluated sample. There is no mask latching.
- out_trig_pulse is high for exactly one cycle per trigger; it is never held across a back-to-back re-arm.
- Reset during HOLDOFF or SEARCH returns to IDLE with no pulse.

## Test plan
- Level trigger:
  - Setup: mask_0=all ones, mask_1=64'h1, holdoff=0, len=1, arm.
  - Samples 0,0,1 → pulse after the third sample, out_trig_index=2, out_state=3.
- Rising edge:
  - Setup: mask_3 bit 5; samples 0x20 (before arm), arm, then 0x20, 0x00, 0x20.
  - Required: trigger at index 2.
  - No trigger at index 0, because prev=0x20.
- Holdoff:
  - Setup: holdoff=3, condition always true.
  - Required: trigger index 3; out_state reads 1 for the first three samples.
- Run length:
  - Setup: len=3; pattern M,M,N,M,M,M.
  - Required: trigger index 5.
  - Also: len=0 behaves as len=1.
- Care mask and contradiction:
  - Setup: mask_1 and mask_2 both set on bit 0.
  - With mask_0 bit 0 set: never triggers over 100 samples.
  - With mask_0 bit 0 cleared: triggers on the first sample.
- Control edge cases:
  - Abort in SEARCH → IDLE in the next cycle.
  - Arm and abort together → IDLE.
  - in_rst_n low mid-SEARCH → all outputs 0 without waiting for a clock edge.
  - Re-arm in DONE → out_triggered cleared and index restarts at 0.
